// File: rtl/instr_type.sv
// Decoded instruction kinds produced by the decode/execute stages.
package instr_type;
  typedef enum logic [3:0] {
    ADD, SUB, ADDI, LUI, LB, LH, LW, LBU, LHU, SB, SH, SW
  } instr_kind_t;
endpackage

// File: rtl/mem_access_pkg.sv
// Types and store/alignment helpers for the memory access stage.
package mem_access_pkg;
  import instr_type::*;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} mac_state_t;

  function automatic logic [3:0] store_strobe(instr_kind_t kind, logic [1:0] addr);
    logic [3:0] strb;
    strb = 4'b0000;
    case (kind)
      SB: strb = 4'b0001 << addr;
      SH: strb = 4'b0011 << addr;
      SW: strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Narrow stores replicate their data so the memory picks the lane via strobes.
  function automatic logic [31:0] store_data(instr_kind_t kind, logic [31:0] data);
    logic [31:0] wdata;
    wdata = 32'h0;
    case (kind)
      SB: wdata = {4{data[7:0]}};
      SH: wdata = {2{data[15:0]}};
      SW: wdata = data;
      default: wdata = 32'h0;
    endcase
    return wdata;
  endfunction

  function automatic logic is_misaligned(instr_kind_t kind, logic [1:0] addr);
    logic mis;
    mis = 1'b0;
    case (kind)
      LH, LHU, SH: mis = addr[0];
      LW, SW:      mis = |addr;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction
endpackage

// File: rtl/register_file_params.sv
// Register file and datapath widths shared across the pipeline.
package register_file_params;
  localparam int OPERAND_WIDTH = 32;
  localparam int REGISTER_DESCRIPTOR_WIDTH = 5;
endpackage

// File: rtl/memory_access_controller_if.sv
// Request/response bus between the memory access stage and the data memory.
interface memory_access_controller_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/load_aligner.sv
// Picks the addressed lane out of a read word and sign/zero extends it.
module load_aligner
  import instr_type::*;
(
  input  instr_kind_t kind,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] value
);
  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    value = rdata;
    case (kind)
      LB:  value = {{24{shifted[7]}}, shifted[7:0]};
      LBU: value = {24'h0, shifted[7:0]};
      LH:  value = {{16{shifted[15]}}, shifted[15:0]};
      LHU: value = {16'h0, shifted[15:0]};
      default: value = rdata;
    endcase
  end
endmodule

// File: rtl/memory_access_controller.sv
// Memory stage: turns execute results into data-memory transactions, with a
// one-cycle registered pass-through for non-memory results.
module memory_access_controller
  import instr_type::*, register_file_params::*, mem_access_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_input,
  input  instr_kind_t                          instr_kind_input,
  input  logic                                 read_memory,
  input  logic                                 write_memory,
  input  logic [OPERAND_WIDTH-1:0]             read_memory_address,
  input  logic [OPERAND_WIDTH-1:0]             write_memory_address,
  input  logic [OPERAND_WIDTH-1:0]             new_memory_value,
  input  logic [OPERAND_WIDTH-1:0]             new_register_value,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr_input,
  input  logic                                 write_register,
  output logic                                 stall_output,
  memory_access_controller_if.master           mem,
  output logic                                 valid_output,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr_output,
  output logic                                 write_register_output,
  output logic [OPERAND_WIDTH-1:0]             register_value_output,
  output logic                                 misaligned_output,
  output logic                                 timeout_output
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  mac_state_t                         state_reg, state_next;
  logic [CW-1:0]                      count_reg, count_next;
  instr_kind_t                        kind_reg, kind_next;
  logic [OPERAND_WIDTH-1:0]           addr_reg, addr_next;
  logic [OPERAND_WIDTH-1:0]           data_reg, data_next;
  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_reg, rd_next;
  logic                               is_load_reg, is_load_next;

  logic                               valid_reg, valid_next;
  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_out_reg, rd_out_next;
  logic                               wreg_reg, wreg_next;
  logic [OPERAND_WIDTH-1:0]           value_reg, value_next;
  logic                               mis_reg, mis_next;
  logic                               to_reg, to_next;

  logic [OPERAND_WIDTH-1:0] sel_addr;
  logic [31:0]              load_value;
  logic                     mem_op, in_req, limit_hit;

  assign sel_addr  = write_memory ? write_memory_address : read_memory_address;
  assign mem_op    = read_memory | write_memory;
  assign in_req    = (state_reg == REQ);
  assign limit_hit = (count_reg == CW'(MAX_WAIT - 1));

  load_aligner u_load_aligner (
    .kind    (kind_reg),
    .addr_lo (addr_reg[1:0]),
    .rdata   (mem.mem_resp_rdata),
    .value   (load_value)
  );

  // Request fields come only from latched state, so they hold while ready is low.
  assign mem.mem_req_valid = in_req;
  assign mem.mem_req_write = in_req & ~is_load_reg;
  assign mem.mem_req_addr  = in_req ? {addr_reg[31:2], 2'b00} : 32'h0;
  assign mem.mem_req_wdata = in_req ? store_data(kind_reg, data_reg) : 32'h0;
  assign mem.mem_req_wstrb = in_req ? store_strobe(kind_reg, addr_reg[1:0]) : 4'h0;

  assign stall_output          = (state_reg != IDLE);
  assign valid_output          = valid_reg;
  assign rd_addr_output        = rd_out_reg;
  assign write_register_output = wreg_reg;
  assign register_value_output = value_reg;
  assign misaligned_output     = mis_reg;
  assign timeout_output        = to_reg;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    kind_next    = kind_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    rd_next      = rd_reg;
    is_load_next = is_load_reg;
    valid_next   = 1'b0;
    rd_out_next  = rd_out_reg;
    wreg_next    = wreg_reg;
    value_next   = value_reg;
    mis_next     = 1'b0;
    to_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_input) begin
          if (!mem_op) begin
            valid_next  = 1'b1;
            rd_out_next = rd_addr_input;
            wreg_next   = write_register;
            value_next  = new_register_value;
          end else if (is_misaligned(instr_kind_input, sel_addr[1:0])) begin
            valid_next  = 1'b1;
            rd_out_next = rd_addr_input;
            wreg_next   = 1'b0;
            value_next  = '0;
            mis_next    = 1'b1;
          end else begin
            state_next   = REQ;
            count_next   = '0;
            kind_next    = instr_kind_input;
            addr_next    = sel_addr;
            data_next    = new_memory_value;
            rd_next      = rd_addr_input;
            is_load_next = read_memory;
          end
        end
      end
      REQ, WAIT: begin
        count_next = count_reg + CW'(1);
        // A response arriving on the last allowed cycle still completes normally.
        if (state_reg == WAIT && mem.mem_resp_valid) begin
          state_next  = IDLE;
          valid_next  = 1'b1;
          rd_out_next = rd_reg;
          wreg_next   = is_load_reg;
          value_next  = is_load_reg ? load_value : '0;
        end else if (limit_hit) begin
          state_next  = IDLE;
          valid_next  = 1'b1;
          rd_out_next = rd_reg;
          wreg_next   = 1'b0;
          value_next  = '0;
          to_next     = 1'b1;
        end else if (state_reg == REQ && mem.mem_req_ready) begin
          state_next = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      kind_reg    <= ADD;
      addr_reg    <= '0;
      data_reg    <= '0;
      rd_reg      <= '0;
      is_load_reg <= 1'b0;
      valid_reg   <= 1'b0;
      rd_out_reg  <= '0;
      wreg_reg    <= 1'b0;
      value_reg   <= '0;
      mis_reg     <= 1'b0;
      to_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      kind_reg    <= kind_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      rd_reg      <= rd_next;
      is_load_reg <= is_load_next;
      valid_reg   <= valid_next;
      rd_out_reg  <= rd_out_next;
      wreg_reg    <= wreg_next;
      value_reg   <= value_next;
      mis_reg     <= mis_next;
      to_reg      <= to_next;
    end
  end
endmodule

// File: tb/tb_memory_access_controller.sv
// Bench for memory_access_controller: directed vector table, random
// transactions against a byte-lane reference model, and reset/late-response cases.
module tb_memory_access_controller;
  import instr_type::*;
  import register_file_params::*;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_input = 1'b0;
  instr_kind_t instr_kind_input = ADD;
  logic        read_memory = 1'b0, write_memory = 1'b0;
  logic [31:0] read_memory_address = '0, write_memory_address = '0;
  logic [31:0] new_memory_value = '0, new_register_value = '0;
  logic [4:0]  rd_addr_input = '0;
  logic        write_register = 1'b0;
  logic        stall_output, valid_output, write_register_output;
  logic        misaligned_output, timeout_output;
  logic [4:0]  rd_addr_output;
  logic [31:0] register_value_output;

  memory_access_controller_if bus();

  memory_access_controller #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .valid_input           (valid_input),
    .instr_kind_input      (instr_kind_input),
    .read_memory           (read_memory),
    .write_memory          (write_memory),
    .read_memory_address   (read_memory_address),
    .write_memory_address  (write_memory_address),
    .new_memory_value      (new_memory_value),
    .new_register_value    (new_register_value),
    .rd_addr_input         (rd_addr_input),
    .write_register        (write_register),
    .stall_output          (stall_output),
    .mem                   (bus),
    .valid_output          (valid_output),
    .rd_addr_output        (rd_addr_output),
    .write_register_output (write_register_output),
    .register_value_output (register_value_output),
    .misaligned_output     (misaligned_output),
    .timeout_output        (timeout_output)
  );

  always #5 clk = ~clk;

  typedef struct {
    instr_kind_t kind;
    logic [31:0] addr, data, rdata;
    int          r, w;
    logic [4:0]  rd;
    logic        wreg_in;
    logic        exp_wreg, exp_mis, exp_to, chk_value;
    logic [31:0] exp_value;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    int          exp_lat;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int kind_bytes(instr_kind_t k);
    case (k)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic logic is_ld(instr_kind_t k);
    return (k == LB) || (k == LBU) || (k == LH) || (k == LHU) || (k == LW);
  endfunction

  function automatic logic is_st(instr_kind_t k);
    return (k == SB) || (k == SH) || (k == SW);
  endfunction

  function automatic vec_t mk(instr_kind_t kind, logic [31:0] addr, logic [31:0] data,
                              logic [31:0] rdata, int r, int w, logic [4:0] rd, logic wreg_in,
                              logic exp_wreg, logic exp_mis, logic exp_to, logic chk_value,
                              logic [31:0] exp_value, logic [3:0] exp_strb,
                              logic [31:0] exp_wdata, int exp_lat);
    vec_t v;
    v.kind = kind; v.addr = addr; v.data = data; v.rdata = rdata; v.r = r; v.w = w;
    v.rd = rd; v.wreg_in = wreg_in; v.exp_wreg = exp_wreg; v.exp_mis = exp_mis;
    v.exp_to = exp_to; v.chk_value = chk_value; v.exp_value = exp_value;
    v.exp_strb = exp_strb; v.exp_wdata = exp_wdata; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Reference model: derives the outcome from byte sizes and lane offsets.
  function automatic vec_t model_vec(instr_kind_t kind, logic [31:0] addr, logic [31:0] data,
                                     logic [31:0] rdata, int r, int w, logic [4:0] rd,
                                     logic wreg_in);
    vec_t   v;
    int     sz, off, cycles;
    longint val;
    logic   mem, mis, to;
    sz  = kind_bytes(kind);
    off = int'(addr % 4);
    mem = (sz != 0);
    mis = mem && ((addr % sz) != 0);
    cycles = r + w + 2;
    to  = mem && !mis && (cycles > MAX_WAIT);
    v = mk(kind, addr, data, rdata, r, w, rd, wreg_in, 1'b0, mis, to, 1'b0, '0, '0, '0, 1);
    if (!mem) begin
      v.exp_wreg = wreg_in; v.chk_value = 1'b1; v.exp_value = data;
    end else if (!mis) begin
      v.exp_lat = ((cycles > MAX_WAIT) ? MAX_WAIT : cycles) + 1;
      if (is_st(kind)) begin
        v.exp_strb = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++) v.exp_wdata[8*i +: 8] = 8'(data >> (8 * (i % sz)));
      end else if (!to) begin
        val = longint'((rdata >> (8 * off))) & ((longint'(1) << (8 * sz)) - 1);
        if ((kind == LB || kind == LH) && val >= (longint'(1) << (8 * sz - 1)))
          val = val - (longint'(1) << (8 * sz));
        v.exp_wreg = 1'b1; v.chk_value = 1'b1; v.exp_value = val[31:0];
      end
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    logic is_l, is_s, exp_req, got;
    int   phase, cnt, lat;
    is_l = is_ld(v.kind);
    is_s = is_st(v.kind);
    exp_req = (is_l || is_s) && !v.exp_mis;
    @(negedge clk);
    valid_input          = 1'b1;
    instr_kind_input     = v.kind;
    read_memory          = is_l;
    write_memory         = is_s;
    read_memory_address  = is_l ? v.addr : $urandom;
    write_memory_address = is_s ? v.addr : $urandom;
    new_memory_value     = is_s ? v.data : $urandom;
    new_register_value   = (is_l || is_s) ? $urandom : v.data;
    rd_addr_input        = v.rd;
    write_register       = v.wreg_in;
    @(posedge clk);
    #1 valid_input = 1'b0;
    phase = exp_req ? 0 : 3;
    cnt = 0; got = 1'b0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("stall_after_accept", stall_output, exp_req);
        if (!exp_req) check("no_mem_req", bus.mem_req_valid, 1'b0);
      end
      if (valid_output) begin
        got = 1'b1; lat = i;
        break;
      end
      if (phase == 0) begin
        check("req_valid", bus.mem_req_valid, 1'b1);
        check("req_addr", bus.mem_req_addr, {v.addr[31:2], 2'b00});
        check("req_wstrb", bus.mem_req_wstrb, v.exp_strb);
        check("req_write", bus.mem_req_write, is_s);
        if (is_s) check("req_wdata", bus.mem_req_wdata, v.exp_wdata);
        if (cnt == v.r) begin
          bus.mem_req_ready = 1'b1; phase = 1; cnt = 0;
        end else begin
          bus.mem_req_ready = 1'b0; cnt++;
        end
      end else if (phase == 1) begin
        bus.mem_req_ready = 1'b0;
        if (cnt == v.w) begin
          bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = v.rdata; phase = 2;
        end else begin
          cnt++;
        end
      end else if (phase == 2) begin
        bus.mem_resp_valid = 1'b0;
      end
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    check("valid_seen", got, 1'b1);
    if (got) begin
      check("latency", lat, v.exp_lat);
      check("rd_addr", rd_addr_output, v.rd);
      check("write_register", write_register_output, v.exp_wreg);
      check("misaligned", misaligned_output, v.exp_mis);
      check("timeout", timeout_output, v.exp_to);
      if (v.chk_value) check("reg_value", register_value_output, v.exp_value);
    end
    $display("txn kind=%s addr=0x%08h r=%0d w=%0d lat=%0d value=0x%08h mis=%0b to=%0b",
             v.kind.name(), v.addr, v.r, v.w, lat, register_value_output,
             misaligned_output, timeout_output);
    @(negedge clk);
    check("pulse_one_cycle", valid_output, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    instr_kind_t kinds[12];
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    kinds = '{ADD, SUB, ADDI, LUI, LB, LH, LW, LBU, LHU, SB, SH, SW};

    repeat (3) @(negedge clk);
    check("rst_valid", valid_output, 1'b0);
    check("rst_stall", stall_output, 1'b0);
    check("rst_req_valid", bus.mem_req_valid, 1'b0);
    check("rst_req_wstrb", bus.mem_req_wstrb, 4'h0);
    check("rst_req_addr", bus.mem_req_addr, 32'h0);
    check("rst_value", register_value_output, 32'h0);
    check("rst_flags", {misaligned_output, timeout_output, write_register_output}, 3'b000);
    rst = 1'b0;

    //             kind  addr          data          rdata         r  w  rd wri wr mis to chk value         strb     wdata         lat
    tbl.push_back(mk(ADDI, 32'h0,      32'h10,       32'h0,        0, 0, 5, 1, 1, 0, 0, 1, 32'h10,       4'h0,    32'h0,        1));
    tbl.push_back(mk(LB,   32'h1003,   32'h0,        32'h80FF_FFFF,0, 0, 7, 0, 1, 0, 0, 1, 32'hFFFF_FF80,4'h0,    32'h0,        3));
    tbl.push_back(mk(SH,   32'h2002,   32'h1234_ABCD,32'h0,        1, 0, 3, 0, 0, 0, 0, 0, 32'h0,        4'b1100, 32'hABCD_ABCD,4));
    tbl.push_back(mk(LW,   32'h3001,   32'h0,        32'h0,        0, 0, 4, 0, 0, 1, 0, 0, 32'h0,        4'h0,    32'h0,        1));
    tbl.push_back(mk(LBU,  32'h1001,   32'h0,        32'h0000_8000,0, 1, 8, 0, 1, 0, 0, 1, 32'h80,       4'h0,    32'h0,        4));
    tbl.push_back(mk(LH,   32'h4002,   32'h0,        32'h8001_0000,0, 0, 9, 0, 1, 0, 0, 1, 32'hFFFF_8001,4'h0,    32'h0,        3));
    tbl.push_back(mk(LHU,  32'h4002,   32'h0,        32'h8001_0000,0, 0, 10,0, 1, 0, 0, 1, 32'h0000_8001,4'h0,    32'h0,        3));
    tbl.push_back(mk(SB,   32'h5001,   32'h0000_00AB,32'h0,        0, 0, 11,0, 0, 0, 0, 0, 32'h0,        4'b0010, 32'hABAB_ABAB,3));
    tbl.push_back(mk(SW,   32'h6000,   32'hDEAD_BEEF,32'h0,        0, 0, 12,0, 0, 0, 0, 0, 32'h0,        4'b1111, 32'hDEAD_BEEF,3));
    tbl.push_back(mk(LW,   32'h7000,   32'h0,        32'hCAFE_F00D,1, 1, 13,0, 1, 0, 0, 1, 32'hCAFE_F00D,4'h0,    32'h0,        5));
    tbl.push_back(mk(SH,   32'h2003,   32'h0,        32'h0,        0, 0, 14,0, 0, 1, 0, 0, 32'h0,        4'h0,    32'h0,        1));
    tbl.push_back(mk(SW,   32'h2002,   32'h0,        32'h0,        0, 0, 15,0, 0, 1, 0, 0, 32'h0,        4'h0,    32'h0,        1));
    tbl.push_back(mk(LH,   32'h8001,   32'h0,        32'h0,        0, 0, 16,0, 0, 1, 0, 0, 32'h0,        4'h0,    32'h0,        1));
    tbl.push_back(mk(ADD,  32'h0,      32'h55,       32'h0,        0, 0, 17,0, 0, 0, 0, 1, 32'h55,       4'h0,    32'h0,        1));
    foreach (tbl[i]) run_txn(tbl[i]);

    // Timeout with no response, then a stray late response must be ignored.
    run_txn(mk(LW, 32'h7004, 32'h0, 32'h1111_2222, 1, 9, 18, 0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 5));
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("late_resp_no_valid", valid_output, 1'b0);
    @(negedge clk);
    check("late_resp_no_valid2", valid_output, 1'b0);
    check("late_resp_no_stall", stall_output, 1'b0);

    // Reset while waiting for a response abandons the transaction silently.
    valid_input = 1'b1; instr_kind_input = LW; read_memory = 1'b1; write_memory = 1'b0;
    read_memory_address = 32'h100; rd_addr_input = 5'd20;
    @(posedge clk);
    #1 valid_input = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("wait_stall", stall_output, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", valid_output, 1'b0);
    check("mid_rst_stall", stall_output, 1'b0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("post_rst_resp_valid", valid_output, 1'b0);
    check("post_rst_req", bus.mem_req_valid, 1'b0);
    @(negedge clk);
    check("post_rst_resp_valid2", valid_output, 1'b0);
    run_txn(mk(ADD, 32'h0, 32'hA5A5_0001, 32'h0, 0, 0, 21, 1, 1, 0, 0, 1, 32'hA5A5_0001, 4'h0, 32'h0, 1));

    for (int n = 0; n < 60; n++) begin
      instr_kind_t k;
      logic [31:0] a;
      k = kinds[$urandom_range(0, 11)];
      a = {$urandom_range(0, 32'h3FFF), 2'b00} | 32'($urandom_range(0, 3));
      run_txn(model_vec(k, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                        5'($urandom_range(0, 31)), 1'($urandom_range(0, 1))));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_access_controller.md
# memory_access_controller

- Sequences the single-port data memory on behalf of the execute stage.
- Accepts one execute-stage result per transaction.
  - Loads and stores are turned into a request/response handshake on the data-memory bus, with byte strobes and load sign/zero extension.
  - Non-memory results pass through with one register stage.
- Sits between `execution` and writeback, and back-pressures the execute stage through `stall_output` while a memory transaction is open.

## Interface
Parameters:
- `MAX_WAIT`, default 255: cycles allowed in REQ+WAIT before the transaction is aborted with a timeout.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` input 1: clock.
  - `rst` input 1: synchronous reset, active-high.
- Execute-stage inputs:
  - `valid_input` input 1: execute result valid.
  - `instr_kind_input` input `instr_kind_t`: decoded instruction kind.
  - `read_memory`, `write_memory` input 1 each: memory op flags from execute.
  - `read_memory_address`, `write_memory_address`, `new_memory_value` input `OPERAND_WIDTH`.
  - `new_register_value` input `OPERAND_WIDTH`; `rd_addr_input` input `REGISTER_DESCRIPTOR_WIDTH`; `write_register` input 1.
  - `stall_output` output 1: upstream must hold its outputs.
- Data-memory request:
  - `mem_req_valid` output 1; `mem_req_ready` input 1.
  - `mem_req_write` output 1.
  - `mem_req_addr` output 32: word-aligned, bits [1:0] always 0.
  - `mem_req_wdata` output 32; `mem_req_wstrb` output 4.
- Data-memory response:
  - `mem_resp_valid` input 1; `mem_resp_rdata` input 32.
- Writeback outputs:
  - `valid_output` output 1: one-cycle pulse.
  - `rd_addr_output` output `REGISTER_DESCRIPTOR_WIDTH`.
  - `write_register_output` output 1.
  - `register_value_output` output `OPERAND_WIDTH`.
- Error flags: `misaligned_output`, `timeout_output` output 1 each, qualified by `valid_output`.

## Operation
States: IDLE, REQ, WAIT.
- **IDLE**, `valid_input`=1:
  - Non-memory op: register rd/value/`write_register` and pulse `valid_output` next cycle; stay in IDLE.
  - Misaligned memory op: pulse `valid_output` next cycle with `misaligned_output`=1 and `write_register_output`=0; no bus request.
    - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - Aligned load or store: latch kind, address, data and rd; go to REQ.
- **REQ**: `mem_req_valid`=1 with latched fields. When `mem_req_ready`=1, go to WAIT.
- **WAIT**: when `mem_resp_valid`=1, go to IDLE and pulse `valid_output` next cycle.
  - Loads: `write_register_output`=1 with the extracted value.
  - Stores: `write_register_output`=0.
- Stores:
  - SB: `mem_req_wstrb`=4'b0001<<addr[1:0]; wdata is byte[7:0] replicated ×4.
  - SH: `mem_req_wstrb`=4'b0011<<addr[1:0]; wdata is half[15:0] replicated ×2.
  - SW: `mem_req_wstrb`=4'b1111; wdata is the full word.
  - Loads: `mem_req_wstrb`=0 and `mem_req_write`=0.
- Loads: the lane is selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Timeout: a cycle counter is cleared on entry to REQ and increments in REQ and WAIT.
  - When it reaches `MAX_WAIT`, go to IDLE and pulse `valid_output` with `timeout_output`=1 and `write_register_output`=0.
- `stall_output` = (state≠IDLE), combinational.
  - While stalled, `valid_input` is ignored; upstream holds.
- `mem_resp_valid` in IDLE or REQ is ignored, including late responses after a timeout.

## Timing
- Reset: state IDLE, counter 0, all outputs 0.
- Reset mid-transaction abandons it with no `valid_output` pulse.
- Non-memory and misaligned latency: 1 cycle after the accepting edge.
- Memory latency: at least 3 cycles after the accepting edge.
  - Cycle 1 is REQ (ready=1), cycle 2 is WAIT (resp=1), cycle 3 is `valid_output`.
- `mem_req_*` fields stay stable while `mem_req_valid`=1 and `mem_req_ready`=0.
- `valid_output` is high for exactly one cycle per accepted instruction.
  - It may coincide with a new acceptance in IDLE.
- Response in the same cycle the counter hits `MAX_WAIT`: the response wins and `timeout_output`=0.

## Structure
- Package `mem_access_pkg`:
  - `mac_state_t` enum (IDLE, REQ, WAIT).
  - Functions `store_strobe(kind, addr[1:0])`, `store_data(kind, data)` and `is_misaligned(kind, addr)`.
  - Reuses `instr_type::instr_kind_t` and `register_file_params`.
- Sub-module `load_aligner`: combinational; inputs are kind, addr[1:0] and rdata; output is the extended 32-bit value.

## Test plan
- ADDI result 0x0000_0010, rd=5, `valid_input`=1 in IDLE → next cycle `valid_output`=1, rd=5, value 0x10, `stall_output` never 1.
- LB at address 0x1003 with ready=1 and a response 1 cycle later carrying rdata 0x80FF_FFFF:
  - `mem_req_addr`=0x1000 and `wstrb`=0.
  - Value 0xFFFF_FF80, `write_register_output`=1, `valid_output` 3 cycles after acceptance.
- SH at address 0x2002 with data 0x1234_ABCD → wstrb 4'b1100, wdata 0xABCD_ABCD, `mem_req_write`=1, `write_register_output`=0 on completion.
- LW at address 0x3001 → no `mem_req_valid`; next cycle `valid_output`=1 with `misaligned_output`=1.
- Timeout and late response, with `MAX_WAIT`=4, ready=1 and no response:
  - After 4 cycles, `valid_output` pulses with `timeout_output`=1 and state returns to IDLE.
  - A later stray `mem_req_resp_valid` produces no output.
- Reset during WAIT, then a response arrives → outputs stay 0, `stall_output`=0, and the next ADD is accepted normally.
